// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - per-bit rising-edge detector producing one-cycle pulses
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out_pulse
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    // History tracks the input level every cycle.
    always_comb begin
        prev_d = in;
    end

    // History register, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Pulse on the first high cycle of each bit.
    always_comb begin
        out_pulse = in & ~prev_q;
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - sampled saturating-counter debouncer with rising-edge pulses
module button_debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise_pulse
);

    localparam int SAMPLE_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int SAT_W    = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_ONE  = SAMPLE_W'(1);
    localparam logic [SAT_W-1:0]    SAT_FULL    = SAT_W'(PULSE_CNT_MAX);
    localparam logic [SAT_W-1:0]    SAT_ONE     = SAT_W'(1);

    logic [SAMPLE_W-1:0] sample_cnt_q;
    logic [SAMPLE_W-1:0] sample_cnt_d;
    logic                sample_tick;

    // Free-running sample timer shared by every channel; ticks on its last count.
    always_comb begin
        sample_tick  = (sample_cnt_q == SAMPLE_LAST);
        sample_cnt_d = sample_tick ? '0 : (sample_cnt_q + SAMPLE_ONE);
    end

    // Sample timer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SAT_W-1:0] sat_cnt_q;
        logic [SAT_W-1:0] sat_cnt_d;

        // A low sample wipes all progress; high samples climb one step per tick up to full.
        always_comb begin
            sat_cnt_d = sat_cnt_q;
            if (!sync_in[i]) begin
                sat_cnt_d = '0;
            end else if (sample_tick && (sat_cnt_q < SAT_FULL)) begin
                sat_cnt_d = sat_cnt_q + SAT_ONE;
            end
        end

        // Per-channel saturating counter register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sat_cnt_q <= '0;
            end else begin
                sat_cnt_q <= sat_cnt_d;
            end
        end

        assign debounced[i] = (sat_cnt_q == SAT_FULL);
    end

    edge_detector #(
        .WIDTH(WIDTH)
    ) u_edge_detector (
        .clk      (clk),
        .rst      (rst),
        .in       (debounced),
        .out_pulse(rise_pulse)
    );

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer against a run-length model
module tb_button_debouncer;

    localparam int WIDTH = 2;
    localparam int SMAX  = 4;
    localparam int PMAX  = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] rise_pulse;

    int checks;
    int errors;

    // Expected {debounced, rise_pulse} after each clock edge, in edge order.
    logic [2*WIDTH-1:0] exp_q[$];

    // Model state: edge index since reset release, start edge of each channel's
    // current high run (-1 when low), and the expected level after the previous edge.
    int               n;
    int               run_start[WIDTH];
    logic [WIDTH-1:0] prev_exp;

    button_debouncer #(
        .WIDTH         (WIDTH),
        .SAMPLE_CNT_MAX(SMAX),
        .PULSE_CNT_MAX (PMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sync_in   (sync_in),
        .debounced (debounced),
        .rise_pulse(rise_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every settled cycle, pop the expectation for the edge just passed.
    initial begin
        logic [2*WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({debounced, rise_pulse} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t deb/rise actual=%b_%b required=%b_%b",
                             $time, debounced, rise_pulse, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    task automatic direct_check(input string name, input logic [2*WIDTH-1:0] act,
                                input logic [2*WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        prev_exp = '0;
        for (int c = 0; c < WIDTH; c++) run_start[c] = -1;
    endtask

    // Ticks land on edges m with m % SMAX == SMAX-1; a level is accepted once the
    // current unbroken high run has covered PMAX of them.
    task automatic cycle(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] deb;
        int               ticks;
        sync_in = val;
        for (int c = 0; c < WIDTH; c++) begin
            if (!val[c]) run_start[c] = -1;
            else if (run_start[c] < 0) run_start[c] = n;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < WIDTH; c++) begin
            if (run_start[c] < 0) begin
                deb[c] = 1'b0;
            end else begin
                ticks  = (n + 1) / SMAX - run_start[c] / SMAX;
                deb[c] = (ticks >= PMAX);
            end
        end
        exp_q.push_back({deb, deb & ~prev_exp});
        prev_exp = deb;
        n++;
    endtask

    task automatic reset_cycle(input logic [WIDTH-1:0] val);
        sync_in = val;
        @(posedge clk);
        #1;
        exp_q.push_back('0);
    endtask

    task automatic hold(input logic [WIDTH-1:0] val, input int cnt);
        for (int k = 0; k < cnt; k++) cycle(val);
    endtask

    // Reset pulsed entirely between edges; outputs must clear with no clock edge.
    task automatic async_reset();
        #5;
        rst = 1'b1;
        #1;
        direct_check("async_reset_clear", {debounced, rise_pulse}, '0);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        sync_in = 2'b11;
        model_reset();

        #1;
        direct_check("reset_immediate", {debounced, rise_pulse}, '0);
        repeat (3) reset_cycle(2'b11);
        rst = 1'b0;
        direct_check("first_cycle_after_release", {debounced, rise_pulse}, '0);

        // Clean press on ch0.
        hold(2'b00, 3);
        hold(2'b01, 16);
        // Bounce: release, 8 high, 1 low, then held.
        hold(2'b00, 2);
        hold(2'b01, 8);
        hold(2'b00, 1);
        hold(2'b01, 16);
        // Release and re-press.
        hold(2'b00, 3);
        hold(2'b01, 16);
        // ch1 pressed while ch0 accepted.
        hold(2'b11, 16);
        // Async reset mid-count after two ticks of a held press.
        hold(2'b00, 2);
        hold(2'b01, 8);
        async_reset();
        hold(2'b01, 16);

        // Randomized presses with occasional bounce glitches.
        v = 2'b00;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if ($urandom_range(0, 9) == 0) v[c] = ~v[c];
            end
            cycle(v);
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        @(negedge clk);
        @(negedge clk);
        direct_check("scoreboard_drained", 4'(exp_q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
